// File: rtl/vend_dispenser.sv
// Product dispenser stage: queues vend requests, runs the motor until a drop is
// sensed, tracks inventory, refunds when sold out and latches a jam on motor timeout.
module vend_dispenser #(
   parameter int INV_W    = 8,
   parameter int INV_INIT = 10,
   parameter int PEND_W   = 3,
   parameter int TIMEOUT  = 16,
   parameter int SETTLE   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vend,
   input  logic              drop_sensor,
   input  logic              restock,
   input  logic [INV_W-1:0]  restock_val,
   input  logic              clear_jam,
   output logic              motor_on,
   output logic              dispensed,
   output logic              refund,
   output logic              overflow,
   output logic              sold_out,
   output logic              jam,
   output logic              busy,
   output logic [INV_W-1:0]  inventory,
   output logic [PEND_W-1:0] pending,
   output logic [1:0]        dbg_state
);

   localparam int TMR_W = $clog2((TIMEOUT > SETTLE ? TIMEOUT : SETTLE) + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_JAM} state_t;

   state_t             state_q, state_d;
   logic [INV_W-1:0]   inv_q, inv_d;
   logic [PEND_W-1:0]  pend_q, pend_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               consume;
   logic               dispensed_q, dispensed_d;
   logic               refund_q, refund_d;
   logic               overflow_q, overflow_d;
   logic               motor_q, jam_q, busy_q, sold_out_q;

   always_comb begin
      state_d     = state_q;
      inv_d       = inv_q;
      timer_d     = timer_q;
      consume     = 1'b0;
      dispensed_d = 1'b0;
      refund_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A restock owns the cycle; the new stock is evaluated next cycle.
            if (restock) begin
               inv_d = restock_val;
            end else if (pend_q != '0) begin
               if (inv_q != '0) begin
                  state_d = S_RUN;
                  timer_d = '0;
               end else begin
                  consume  = 1'b1;
                  refund_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (drop_sensor) begin
               state_d     = S_SETTLE;
               inv_d       = inv_q - 1'b1;
               consume     = 1'b1;
               dispensed_d = 1'b1;
               timer_d     = '0;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d = S_JAM;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (timer_q == TMR_W'(SETTLE - 1)) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_JAM: begin
            if (clear_jam) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A new request and a consumed one in the same cycle cancel out.
   always_comb begin
      pend_d     = pend_q;
      overflow_d = 1'b0;
      if (vend && !consume) begin
         if (pend_q == PEND_MAX) overflow_d = 1'b1;
         else                    pend_d     = pend_q + 1'b1;
      end else if (!vend && consume) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         inv_q       <= INV_W'(INV_INIT);
         pend_q      <= '0;
         timer_q     <= '0;
         dispensed_q <= 1'b0;
         refund_q    <= 1'b0;
         overflow_q  <= 1'b0;
         motor_q     <= 1'b0;
         jam_q       <= 1'b0;
         busy_q      <= 1'b0;
         sold_out_q  <= (INV_INIT == 0);
      end else begin
         state_q     <= state_d;
         inv_q       <= inv_d;
         pend_q      <= pend_d;
         timer_q     <= timer_d;
         dispensed_q <= dispensed_d;
         refund_q    <= refund_d;
         overflow_q  <= overflow_d;
         motor_q     <= (state_d == S_RUN);
         jam_q       <= (state_d == S_JAM);
         busy_q      <= (state_d != S_IDLE);
         sold_out_q  <= (inv_d == '0);
      end
   end

   assign motor_on  = motor_q;
   assign dispensed = dispensed_q;
   assign refund    = refund_q;
   assign overflow  = overflow_q;
   assign sold_out  = sold_out_q;
   assign jam       = jam_q;
   assign busy      = busy_q;
   assign inventory = inv_q;
   assign pending   = pend_q;
   assign dbg_state = state_q;

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of the vending FSM. Consumes its 1-bit dispense request, `vend`.
- Queues requests, drives the product motor until the drop sensor confirms delivery, and tracks inventory.
- Issues refunds when sold out and latches a jam fault on motor timeout.
- Sits between the coin/vend FSM and the physical dispenser hardware.

Parameters:
- INV_W, 8: inventory counter width.
- INV_INIT, 10: inventory loaded at reset.
- PEND_W, 3: pending-request counter width; maximum pending is 2^PEND_W-1 = 7.
- TIMEOUT, 16: motor cycles allowed without a drop before a jam is declared.
- SETTLE, 4: motor-off cycles after a successful drop.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- vend  in  1  dispense request; every cycle it is high counts as one request
- drop_sensor  in  1  product-drop detector, high for at least 1 cycle
- restock  in  1  load inventory with restock_val
- restock_val  in  INV_W  new inventory value
- clear_jam  in  1  leave JAM state
- motor_on  out  1  drive dispenser motor
- dispensed  out  1  1-cycle pulse per confirmed product
- refund  out  1  1-cycle pulse per request cancelled because sold out
- overflow  out  1  1-cycle pulse when a request is lost because pending is full
- sold_out  out  1  inventory == 0
- jam  out  1  jam fault, level
- busy  out  1  state != IDLE
- inventory  out  INV_W  current stock
- pending  out  PEND_W  queued requests

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, inventory=INV_INIT, pending=0, timer=0, motor_on=0, dispensed=0, refund=0, overflow=0, jam=0, busy=0, sold_out=(INV_INIT==0).
- Reset mid-operation: motor drops next edge; queued requests are discarded.
- States: IDLE, RUN, SETTLE, JAM.
  - motor_on=1 only in RUN.
  - jam=1 only in JAM.
  - busy=1 in RUN, SETTLE and JAM.
- Pending counter, updated every cycle in all states:
  - increment when vend=1;
  - decrement when a request is consumed (drop confirmed, or refund);
  - increment and decrement in the same cycle leaves it unchanged;
  - vend=1 while pending==max with no decrement: request is dropped, overflow pulses, pending stays at max.
- IDLE:
  - pending>0 and inventory>0: go to RUN, timer=0.
  - pending>0 and inventory==0: stay IDLE, consume one request, pulse refund. One refund per cycle until pending==0, with no gaps.
  - restock=1: inventory<=restock_val. It takes priority over that cycle's RUN/refund decision; evaluation resumes next cycle with the new value.
- RUN:
  - timer increments each cycle.
  - drop_sensor=1: go to SETTLE, inventory-1, pending-1, dispensed pulse (same edge), timer=0.
  - Else timer==TIMEOUT-1: go to JAM. Inventory and pending are unchanged; the request stays queued.
  - drop_sensor takes precedence over timeout in the same cycle.
- SETTLE: motor off for SETTLE cycles, then IDLE.
- JAM:
  - motor off; vend requests still accumulate, with overflow as above.
  - clear_jam=1: go to IDLE, which retries the queued request.
  - Only clear_jam or reset exits JAM.
- restock outside IDLE is ignored.
- drop_sensor outside RUN is ignored (no dispensed pulse, no inventory change).
- sold_out tracks the registered inventory, updated the same edge inventory changes.
- Inventory never underflows, because RUN is only entered with inventory>0.
- Latency from vend=1 at edge t (state IDLE, inventory>0):
  - t+1: pending=1;
  - t+2: state RUN, motor_on=1;
  - drop_sensor at edge d: motor_on=0 and dispensed=1 at d+1.

Test Plan:
1. Reset, then a single vend pulse; drop_sensor at 3rd RUN cycle -> motor_on high 3 cycles, dispensed pulses once, inventory 10->9, pending 1->0, busy low after SETTLE=4 cycles.
2. vend high 3 consecutive cycles, drop after 2 motor cycles each time -> three RUN/SETTLE sequences, 3 dispensed pulses, inventory 10->7, no overflow.
3. Inventory=1 via restock (restock_val=1 in IDLE), then 3 vend pulses -> 1 dispensed, sold_out=1, then exactly 2 refund pulses on back-to-back cycles, pending=0.
4. vend with no drop_sensor -> motor_on high exactly 16 cycles, jam=1, inventory unchanged, pending=1. clear_jam then drop -> dispensed, jam=0, inventory-1.
5. In JAM, vend held high 8 cycles with pending starting at 1 -> pending saturates at 7, overflow pulses on the cycles where pending was already 7.
6. Assert reset during RUN -> next edge motor_on=0, pending=0, inventory=10, state IDLE. drop_sensor the following cycle produces no dispensed pulse.
